// File: rtl/mul_sched_pkg.sv
// Shared constants and types for the MULTU scheduler.
package mul_sched_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t RUN  = 2'd1;
  localparam state_t DONE = 2'd2;

  localparam int unsigned MUL_ITER_DEF = 32;

  localparam logic MF_HI = 1'b0;
  localparam logic MF_LO = 1'b1;

endpackage

// File: rtl/mul_sched_if.sv
// Pipeline-side bundle of the multiply scheduler: issue, HI/LO read and stall.
interface mul_sched_if;
  logic        start;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        mf_req;
  logic        mf_sel;
  logic        stall;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] rd_data;

  modport master (
    output start, op_a, op_b, mf_req, mf_sel,
    input  stall, busy, done, hi, lo, rd_data
  );

  modport slave (
    input  start, op_a, op_b, mf_req, mf_sel,
    output stall, busy, done, hi, lo, rd_data
  );
endinterface

// File: rtl/mul_sched_dp.sv
// Shift-add multiply datapath: operand register, 33-bit adder, 64-bit product shifter.
module mul_dp (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        step,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic [63:0] product,
  output logic [63:0] product_nxt
);

  logic [31:0] a_reg;
  logic [32:0] sum;

  // One iteration: conditional add of the multiplicand into the upper half, then shift right.
  always_comb begin
    sum         = {1'b0, product[63:32]} + {1'b0, a_reg};
    product_nxt = product[0] ? {sum, product[31:1]} : {1'b0, product[63:1]};
  end

  // The upper half is cleared on load; the multiplier rides in the lower half and is
  // consumed LSB-first as the product shifts in from the top.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg   <= '0;
      product <= '0;
    end else if (load) begin
      a_reg   <= op_a;
      product <= {32'd0, op_b};
    end else if (step) begin
      product <= product_nxt;
    end
  end

endmodule

// File: rtl/mul_sched.sv
// MULTU scheduler: FSM, iteration counter, architectural HI/LO and pipeline stall.
module mul_sched
  import mul_sched_pkg::*;
#(
  parameter int unsigned MUL_ITER = MUL_ITER_DEF
) (
  input  logic       clk,
  input  logic       rst,
  mul_sched_if.slave bus
);

  localparam int unsigned CW = $clog2(MUL_ITER + 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [31:0]   hi_r;
  logic [31:0]   lo_r;
  logic [63:0]   product;
  logic [63:0]   product_nxt;
  logic          accept;
  logic          step;
  logic          last;

  // Issue is accepted only outside RUN; reset wins over start.
  always_comb begin
    accept = ~rst & bus.start & (state != RUN);
    step   = ~rst & (state == RUN);
    last   = (cnt == CW'(MUL_ITER - 1));
  end

  mul_dp u_dp (
    .clk         (clk),
    .rst         (rst),
    .load        (accept),
    .step        (step),
    .op_a        (bus.op_a),
    .op_b        (bus.op_b),
    .product     (product),
    .product_nxt (product_nxt)
  );

  // Control FSM, counter and HI/LO commit on the final iteration.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      hi_r  <= '0;
      lo_r  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state <= RUN;
            cnt   <= '0;
          end
        end
        RUN: begin
          cnt <= cnt + CW'(1);
          if (last) begin
            hi_r  <= product_nxt[63:32];
            lo_r  <= product_nxt[31:0];
            state <= DONE;
          end
        end
        DONE: begin
          if (bus.start) begin
            state <= RUN;
            cnt   <= '0;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Status, stall and HI/LO read port.
  always_comb begin
    bus.busy    = (state == RUN);
    bus.done    = (state == DONE);
    bus.stall   = (bus.start & (state == RUN)) |
                  (bus.mf_req & ((state == RUN) | accept));
    bus.hi      = hi_r;
    bus.lo      = lo_r;
    bus.rd_data = (bus.mf_sel == MF_LO) ? lo_r : hi_r;
  end

endmodule
